// File: rtl/sram_scan_pkg.sv
// sram_scan_pkg -- shared definitions for the serial SRAM front-end.
//   op_e     : command opcodes carried in the top two frame bits
//   state_e  : sequencer states of sram_scan_ctrl
//   frame_*  : frame width and field offsets, as functions of the
//              field widths (frame is {op, len, addr, wmask, data}, MSB first)
package sram_scan_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_WR  = 2'b01,
        OP_RD  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } state_e;

    function automatic int unsigned frame_width(int unsigned lw, int unsigned aw,
                                                int unsigned mw, int unsigned dw);
        return 2 + lw + aw + mw + dw;
    endfunction

    function automatic int unsigned frame_off_wmask(int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned frame_off_addr(int unsigned mw, int unsigned dw);
        return dw + mw;
    endfunction

    function automatic int unsigned frame_off_len(int unsigned aw, int unsigned mw,
                                                  int unsigned dw);
        return dw + mw + aw;
    endfunction

    function automatic int unsigned frame_off_op(int unsigned lw, int unsigned aw,
                                                 int unsigned mw, int unsigned dw);
        return dw + mw + aw + lw;
    endfunction

endpackage

// File: rtl/sram_scan_shifter.sv
// sram_scan_shifter -- serial side of the SRAM front-end.
// Shifts command frames in MSB first, counts frame bits and shifts the
// result register out on scan_out_o while the next frame arrives.
// Optional macro SRAM_SCAN_SIG_EN: loaded words are folded into the result
// as a rotate-and-xor signature instead of replacing it.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   scan_in_i         serial frame bit
//   shift_en_i        shift one bit this cycle (host strobe gated by idle)
//   frame_o           frame value including the current scan_in_i bit
//   frame_last_o      this cycle's bit completes a frame
//   res_clear_i       clear result (start of a signature burst)
//   res_load_i        capture res_val_i into the result
//   res_val_i         read data word
//   scan_out_o        MSB of the result register
module sram_scan_shifter
    import sram_scan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FRAME_WIDTH = 46
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   scan_in_i,
    input  logic                   shift_en_i,
    output logic [FRAME_WIDTH-1:0] frame_o,
    output logic                   frame_last_o,
    input  logic                   res_clear_i,
    input  logic                   res_load_i,
    input  logic [DATA_WIDTH-1:0]  res_val_i,
    output logic                   scan_out_o
);

    localparam int unsigned CNT_W = $clog2(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WIDTH - 1);

    logic [FRAME_WIDTH-1:0] frame_sr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  result_q;

    // The frame is presented combinationally so the sequencer can decode it
    // on the same edge that shifts in its last bit.
    always_comb begin
        frame_o      = {frame_sr_q[FRAME_WIDTH-2:0], scan_in_i};
        frame_last_o = shift_en_i && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_sr_q <= '0;
            cnt_q      <= '0;
        end else if (shift_en_i) begin
            frame_sr_q <= frame_o;
            cnt_q      <= frame_last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

`ifdef SRAM_SCAN_SIG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else if (res_clear_i) begin
            result_q <= '0;
        end else if (res_load_i) begin
            result_q <= {result_q[DATA_WIDTH-2:0], result_q[DATA_WIDTH-1]} ^ res_val_i;
        end else if (shift_en_i) begin
            result_q <= {result_q[DATA_WIDTH-2:0], 1'b0};
        end
    end
`else
    // Without the signature the result is simply overwritten per word.
    logic unused_res_clear;
    assign unused_res_clear = res_clear_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else if (res_load_i) begin
            result_q <= res_val_i;
        end else if (shift_en_i) begin
            result_q <= {result_q[DATA_WIDTH-2:0], 1'b0};
        end
    end
`endif

    assign scan_out_o = result_q[DATA_WIDTH-1];

endmodule

// File: rtl/sram_scan_ctrl.sv
// sram_scan_ctrl -- serial command front-end for a 1RW OpenRAM macro.
// A host shifts {op, len, addr, wmask, data} frames in on scan_in; the block
// runs a single or burst write/read on the SRAM port and returns read data
// on scan_out while the next frame shifts in.
// Optional macro SRAM_SCAN_SIG_EN: read bursts fold all words into a
// signature instead of keeping only the last word.
// Ports:
//   clk, rst          clock (also SRAM clk0), synchronous active-high reset
//   scan_in           serial frame data, MSB first
//   scan_enable       shift strobe, one bit per clk
//   scan_out          MSB of the result register
//   busy              a frame is executing
//   done              one-cycle completion pulse
//   err               sticky overrun / reserved-opcode flag
//   sram_csb, sram_web, sram_wmask, sram_addr, sram_din  SRAM drive
//   sram_dout         SRAM read data
module sram_scan_ctrl
    import sram_scan_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WMASK_WIDTH = 4,
    parameter int unsigned LEN_WIDTH   = 4,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_in,
    input  logic                   scan_enable,
    output logic                   scan_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int unsigned FRAME_WIDTH =
        frame_width(LEN_WIDTH, ADDR_WIDTH, WMASK_WIDTH, DATA_WIDTH);
    localparam int unsigned OFF_WMASK = frame_off_wmask(DATA_WIDTH);
    localparam int unsigned OFF_ADDR  = frame_off_addr(WMASK_WIDTH, DATA_WIDTH);
    localparam int unsigned OFF_LEN   = frame_off_len(ADDR_WIDTH, WMASK_WIDTH, DATA_WIDTH);
    localparam int unsigned OFF_OP    =
        frame_off_op(LEN_WIDTH, ADDR_WIDTH, WMASK_WIDTH, DATA_WIDTH);
    localparam int unsigned LAT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;
    logic                   csb_q, csb_d;
    logic                   web_q, web_d;
    logic                   err_q, err_d;

    logic [FRAME_WIDTH-1:0] frame;
    logic                   frame_last;
    logic                   shift_en;
    logic                   res_clear;
    logic                   res_load;

    op_e                    f_op;
    logic [LEN_WIDTH-1:0]   f_len;
    logic [ADDR_WIDTH-1:0]  f_addr;
    logic [WMASK_WIDTH-1:0] f_wmask;
    logic [DATA_WIDTH-1:0]  f_data;

    sram_scan_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_WIDTH (FRAME_WIDTH)
    ) u_shifter (
        .clk_i        (clk),
        .rst_i        (rst),
        .scan_in_i    (scan_in),
        .shift_en_i   (shift_en),
        .frame_o      (frame),
        .frame_last_o (frame_last),
        .res_clear_i  (res_clear),
        .res_load_i   (res_load),
        .res_val_i    (sram_dout),
        .scan_out_o   (scan_out)
    );

    always_comb begin
        f_op    = op_e'(frame[OFF_OP +: 2]);
        f_len   = frame[OFF_LEN +: LEN_WIDTH];
        f_addr  = frame[OFF_ADDR +: ADDR_WIDTH];
        f_wmask = frame[OFF_WMASK +: WMASK_WIDTH];
        f_data  = frame[DATA_WIDTH-1:0];
    end

    // SRAM strobes are registered: csb_d/web_d describe the state being
    // entered, so the pins line up with the state register.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        din_d     = din_q;
        csb_d     = 1'b1;
        web_d     = web_q;
        err_d     = err_q;
        res_clear = 1'b0;
        res_load  = 1'b0;
        shift_en  = scan_enable && (state_q == IDLE);

        // Bits offered while a frame executes are dropped and flagged.
        if (scan_enable && (state_q != IDLE)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_last) begin
                    wcnt_d = f_len;
                    unique case (f_op)
                        OP_WR: begin
                            state_d = WR;
                            addr_d  = f_addr;
                            wmask_d = f_wmask;
                            din_d   = f_data;
                            csb_d   = 1'b0;
                            web_d   = 1'b0;
                        end
                        OP_RD: begin
                            state_d   = RD_ISSUE;
                            addr_d    = f_addr;
                            csb_d     = 1'b0;
                            web_d     = 1'b1;
                            res_clear = 1'b1;
                        end
                        OP_NOP: begin
                            state_d = DONE;
                            web_d   = 1'b1;
                        end
                        default: begin
                            state_d = DONE;
                            web_d   = 1'b1;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            WR: begin
                if (wcnt_q == '0) begin
                    state_d = DONE;
                    web_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - LEN_WIDTH'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    csb_d  = 1'b0;
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                lat_d   = LAT_LAST;
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    res_load = 1'b1;
                    if (wcnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_ISSUE;
                        wcnt_d  = wcnt_q - LEN_WIDTH'(1);
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        csb_d   = 1'b0;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            lat_q   <= '0;
            addr_q  <= '0;
            wmask_q <= '0;
            din_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            din_q   <= din_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            err_q   <= err_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign sram_csb   = csb_q;
    assign sram_web   = web_q;
    assign sram_wmask = wmask_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;

endmodule
